// File: rtl/GLOBAL_PARAM.sv
// Shared datapath constants for the PE accumulate path and the saturating-add helper.
// Every lane is ACC_W bits; a buffer word carries BATCH lanes.
package GLOBAL_PARAM;
    localparam int BATCH = 4;
    localparam int ACC_W = 32;

    // Clamp an ACC_W+1-bit signed sum into the ACC_W-bit signed range.
    function automatic logic [ACC_W-1:0] sat(input logic [ACC_W:0] sum);
        logic [ACC_W-1:0] r;
        r = sum[ACC_W-1:0];
        if (sum[ACC_W] != sum[ACC_W-1]) begin
            r = {sum[ACC_W], {(ACC_W-1){~sum[ACC_W]}}};
        end
        return r;
    endfunction
endpackage

// File: rtl/acc_ram.sv
// Accumulate buffer storage: one write port, one read port, read-first, 1-cycle read latency.
// The caller is responsible for only writing in-range addresses.
module acc_ram #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256,
    parameter int WIDTH  = 128
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]  wr_dat_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [WIDTH-1:0]  rd_dat_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_dat_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_dat_i;
        end
        rd_dat_q <= mem_q[rd_addr_i];
    end

    assign rd_dat_o = rd_dat_q;
endmodule

// File: rtl/pe_acc_buf.sv
// Two-stage read-modify-write accumulate buffer with stage-B forwarding, one op per cycle.
// Readouts are returned one cycle after acceptance and are refused whenever an accumulate is issued.
module pe_acc_buf
    import GLOBAL_PARAM::BATCH;
    import GLOBAL_PARAM::sat;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256,
    parameter int ACC_W  = GLOBAL_PARAM::ACC_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mac_valid,
    input  logic [BATCH*ACC_W-1:0] mac_data,
    input  logic [ADDR_W-1:0]      abuf_addr,
    input  logic [BATCH-1:0]       abuf_acc_en,
    input  logic                   abuf_acc_new,
    input  logic                   rd_en,
    input  logic [ADDR_W-1:0]      rd_addr,
    output logic                   rd_ready,
    output logic [BATCH*ACC_W-1:0] rd_data,
    output logic                   rd_valid,
    output logic                   busy
);
    localparam int W = BATCH * ACC_W;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic              b_vld_q, b_new_q, r_vld_q;
    logic              fwd_d, fwd_q, oor_d, oor_q;
    logic [ADDR_W-1:0] b_addr_q, a_addr;
    logic [BATCH-1:0]  b_en_q;
    logic [W-1:0]      b_dat_q, fwd_dat_q, ram_dat, old_word, new_word;
    logic              a_rd_acc, b_we;

    assign rd_ready = ~mac_valid;
    assign a_rd_acc = rd_en & ~mac_valid;
    assign a_addr   = mac_valid ? abuf_addr : rd_addr;
    assign b_we     = b_vld_q & rst & ({1'b0, b_addr_q} < DEPTH_L);
    assign fwd_d    = b_we & (a_addr == b_addr_q);
    assign oor_d    = ({1'b0, a_addr} >= DEPTH_L);

    acc_ram #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .WIDTH(W)) u_ram (
        .clk       (clk),
        .wr_en_i   (b_we),
        .wr_addr_i (b_addr_q),
        .wr_dat_i  (new_word),
        .rd_addr_i (a_addr),
        .rd_dat_o  (ram_dat)
    );

    // Stage B: the RAM read is stale when the previous cycle wrote the same word.
    always_comb begin
        old_word = fwd_q ? fwd_dat_q : ram_dat;
        if (oor_q) begin
            old_word = '0;
        end
        new_word = old_word;
        for (int i = 0; i < BATCH; i++) begin
            if (b_en_q[i]) begin
                new_word[i*ACC_W +: ACC_W] = b_new_q ? b_dat_q[i*ACC_W +: ACC_W]
                    : sat({old_word[i*ACC_W+ACC_W-1], old_word[i*ACC_W +: ACC_W]}
                        + {b_dat_q[i*ACC_W+ACC_W-1], b_dat_q[i*ACC_W +: ACC_W]});
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            b_vld_q <= 1'b0;
            r_vld_q <= 1'b0;
            fwd_q   <= 1'b0;
        end else begin
            b_vld_q <= mac_valid;
            r_vld_q <= a_rd_acc;
            fwd_q   <= fwd_d;
        end
    end

    always_ff @(posedge clk) begin
        b_addr_q  <= abuf_addr;
        b_en_q    <= abuf_acc_en;
        b_new_q   <= abuf_acc_new;
        b_dat_q   <= mac_data;
        fwd_dat_q <= new_word;
        oor_q     <= oor_d;
    end

    assign rd_valid = r_vld_q & rst;
    assign rd_data  = rd_valid ? old_word : '0;
    assign busy     = rst & (mac_valid | b_vld_q);
endmodule

// File: tb/tb_pe_acc_buf.sv
// Directed vector table plus randomized ops checked against a lane-array reference model.
module tb_pe_acc_buf;
    localparam int DEPTH = 240;

    logic         clk = 1'b0;
    logic         rst, mac_valid, abuf_acc_new, rd_en;
    logic [127:0] mac_data;
    logic [7:0]   abuf_addr, rd_addr;
    logic [3:0]   abuf_acc_en;
    logic         rd_ready, rd_valid, busy;
    logic [127:0] rd_data;

    int n_vec = 0;
    int n_bad = 0;

    pe_acc_buf #(.ADDR_W(8), .DEPTH(DEPTH), .ACC_W(32)) dut (
        .clk(clk), .rst(rst), .mac_valid(mac_valid), .mac_data(mac_data),
        .abuf_addr(abuf_addr), .abuf_acc_en(abuf_acc_en), .abuf_acc_new(abuf_acc_new),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_ready(rd_ready), .rd_data(rd_data),
        .rd_valid(rd_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         mv;
        logic [7:0]   addr;
        logic [3:0]   en;
        logic         nw;
        logic [31:0]  d;
        logic         re;
        logic [7:0]   ra;
        logic         e_rvld;
        logic [127:0] e_rd;
        logic         e_busy;
    } vec_t;

    vec_t tbl [23];

    // Reference model: one 4-lane word per address, updated at issue time.
    logic [31:0]  mdl [256][4];
    logic         pend_v, prev_mv;
    logic [127:0] pend_d;

    function automatic logic [127:0] lanes(input logic [31:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    function automatic vec_t mk(input logic mv, input logic [7:0] addr, input logic [3:0] en,
                                input logic nw, input logic [31:0] d, input logic re,
                                input logic [7:0] ra, input logic e_rvld,
                                input logic [127:0] e_rd, input logic e_busy);
        vec_t v;
        v.mv = mv; v.addr = addr; v.en = en; v.nw = nw; v.d = d;
        v.re = re; v.ra = ra; v.e_rvld = e_rvld; v.e_rd = e_rd; v.e_busy = e_busy;
        return v;
    endfunction

    function automatic logic [31:0] msat(input logic [31:0] a, input logic [31:0] b);
        longint s;
        s = longint'($signed(a)) + longint'($signed(b));
        if (s > 64'sd2147483647) s = 64'sd2147483647;
        if (s < -64'sd2147483648) s = -64'sd2147483648;
        return s[31:0];
    endfunction

    function automatic logic [127:0] mread(input logic [7:0] a);
        if (int'(a) >= DEPTH) return '0;
        return {mdl[a][3], mdl[a][2], mdl[a][1], mdl[a][0]};
    endfunction

    function automatic logic [31:0] rlane();
        case ($urandom_range(0, 3))
            0:       return 32'h7FFF_FF00 + 32'($urandom_range(0, 255));
            1:       return 32'h8000_0000 + 32'($urandom_range(0, 255));
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic mv, input logic [7:0] a, input logic [3:0] en,
                         input logic nw, input logic [127:0] d, input logic re,
                         input logic [7:0] ra);
        @(posedge clk);
        #1;
        mac_valid = mv; abuf_addr = a; abuf_acc_en = en; abuf_acc_new = nw;
        mac_data = d; rd_en = re; rd_addr = ra;
        #1;
    endtask

    task automatic mstep(input logic mv, input logic [7:0] a, input logic [3:0] en,
                         input logic nw, input logic [127:0] d, input logic re,
                         input logic [7:0] ra);
        drive(mv, a, en, nw, d, re, ra);
        chk("rnd_rd_ready", rd_ready, !mv);
        chk("rnd_busy", busy, mv | prev_mv);
        chk("rnd_rd_valid", rd_valid, pend_v);
        if (pend_v) chk("rnd_rd_data", rd_data, pend_d);
        pend_v = re & ~mv;
        if (re & ~mv) pend_d = mread(ra);
        if (mv && int'(a) < DEPTH) begin
            for (int i = 0; i < 4; i++) begin
                if (en[i]) mdl[a][i] = nw ? d[i*32 +: 32] : msat(mdl[a][i], d[i*32 +: 32]);
            end
        end
        prev_mv = mv;
    endtask

    initial begin
        logic [127:0] rd;
        rst = 1'b0; mac_valid = 1'b0; mac_data = '0; abuf_addr = '0; abuf_acc_en = '0;
        abuf_acc_new = 1'b0; rd_en = 1'b0; rd_addr = '0;

        tbl[0]  = mk(1, 3, 4'hF, 1, 32'd5,         0, 0,   0, '0, 1);
        tbl[1]  = mk(1, 3, 4'hF, 0, 32'd7,         0, 0,   0, '0, 1);
        tbl[2]  = mk(0, 0, 4'h0, 0, 32'd0,         1, 3,   0, '0, 1);
        tbl[3]  = mk(0, 0, 4'h0, 0, 32'd0,         0, 0,   1, {4{32'd12}}, 0);
        tbl[4]  = mk(1, 5, 4'hF, 1, 32'h7FFFFFF0,  0, 0,   0, '0, 1);
        tbl[5]  = mk(1, 5, 4'h1, 0, 32'h20,        0, 0,   0, '0, 1);
        tbl[6]  = mk(1, 6, 4'hF, 1, 32'd0,         0, 0,   0, '0, 1);
        tbl[7]  = mk(1, 6, 4'hF, 0, 32'h80000001,  0, 0,   0, '0, 1);
        tbl[8]  = mk(1, 6, 4'hF, 0, 32'h80000001,  0, 0,   0, '0, 1);
        tbl[9]  = mk(0, 0, 4'h0, 0, 32'd0,         1, 5,   0, '0, 1);
        tbl[10] = mk(0, 0, 4'h0, 0, 32'd0,         1, 6,   1,
                     lanes(32'h7FFFFFFF, 32'h7FFFFFF0, 32'h7FFFFFF0, 32'h7FFFFFF0), 0);
        tbl[11] = mk(0, 0, 4'h0, 0, 32'd0,         0, 0,   1, {4{32'h80000000}}, 0);
        tbl[12] = mk(1, 9, 4'hF, 1, 32'd9,         0, 0,   0, '0, 1);
        tbl[13] = mk(1, 9, 4'h5, 0, 32'd1,         0, 0,   0, '0, 1);
        tbl[14] = mk(0, 0, 4'h0, 0, 32'd0,         1, 9,   0, '0, 1);
        tbl[15] = mk(0, 0, 4'h0, 0, 32'd0,         0, 0,   1, lanes(10, 9, 10, 9), 0);
        tbl[16] = mk(1, 9, 4'hF, 0, 32'd1,         1, 9,   0, '0, 1);
        tbl[17] = mk(0, 0, 4'h0, 0, 32'd0,         0, 0,   0, '0, 1);
        tbl[18] = mk(0, 0, 4'h0, 0, 32'd0,         1, 9,   0, '0, 0);
        tbl[19] = mk(0, 0, 4'h0, 0, 32'd0,         0, 0,   1, lanes(11, 10, 11, 10), 0);
        tbl[20] = mk(1, 250, 4'hF, 1, 32'h55,      0, 0,   0, '0, 1);
        tbl[21] = mk(0, 0, 4'h0, 0, 32'd0,         1, 250, 0, '0, 1);
        tbl[22] = mk(0, 0, 4'h0, 0, 32'd0,         0, 0,   1, '0, 0);

        // Reset state, including a stray request while reset is held.
        repeat (3) @(posedge clk);
        #1; mac_valid = 1'b1; rd_en = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_ready", rd_ready, 0);
        mac_valid = 1'b0; rd_en = 1'b0;
        @(posedge clk); #1; rst = 1'b1; #1;
        chk("post_rst_rd_ready", rd_ready, 1);

        for (int i = 0; i < 23; i++) begin
            drive(tbl[i].mv, tbl[i].addr, tbl[i].en, tbl[i].nw, {4{tbl[i].d}},
                  tbl[i].re, tbl[i].ra);
            chk($sformatf("vec%0d_rd_ready", i), rd_ready, !tbl[i].mv);
            chk($sformatf("vec%0d_busy", i), busy, tbl[i].e_busy);
            chk($sformatf("vec%0d_rd_valid", i), rd_valid, tbl[i].e_rvld);
            if (tbl[i].e_rvld) chk($sformatf("vec%0d_rd_data", i), rd_data, tbl[i].e_rd);
        end

        // Reset landing on the stage-B write cycle must drop that write.
        drive(1, 2, 4'hF, 1, {4{32'h11}}, 0, 0);
        drive(0, 0, 4'h0, 0, '0, 0, 0);
        drive(1, 2, 4'hF, 0, {4{32'h1}}, 0, 0);
        @(posedge clk); #1;
        rst = 1'b0; mac_valid = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_rd_valid", rd_valid, 0);
        chk("midrst_rd_data", rd_data, 0);
        @(posedge clk); #1; rst = 1'b1; #1;
        chk("after_rst_busy", busy, 0);
        drive(1, 7, 4'hF, 1, {4{32'h3}}, 1, 2);
        chk("after_rst_rd_ready", rd_ready, 0);
        drive(0, 0, 4'h0, 0, '0, 1, 2);
        chk("rejected_rd_valid", rd_valid, 0);
        drive(0, 0, 4'h0, 0, '0, 0, 0);
        chk("midrst_word", rd_valid ? rd_data : '1, {4{32'h11}});

        // Random phase: fill every word, then 256 back-to-back random ops, then read all back.
        pend_v = 1'b0; prev_mv = 1'b0; pend_d = '0;
        mstep(0, 0, 4'h0, 0, '0, 0, 0);
        for (int a = 0; a < 256; a++) begin
            rd = {rlane(), rlane(), rlane(), rlane()};
            mstep(1, 8'(a), 4'hF, 1, rd, 0, 0);
        end
        for (int k = 0; k < 256; k++) begin
            rd = {rlane(), rlane(), rlane(), rlane()};
            mstep(1, 8'($urandom_range(0, 255)), 4'($urandom), ($urandom_range(0, 3) == 0),
                  rd, 1'($urandom), 8'($urandom));
        end
        mstep(0, 0, 4'h0, 0, '0, 0, 0);
        mstep(0, 0, 4'h0, 0, '0, 0, 0);
        for (int a = 0; a < 256; a++) begin
            mstep(0, 0, 4'h0, 0, '0, 1, 8'(a));
        end
        mstep(0, 0, 4'h0, 0, '0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
